ahb_burst_slave: RTL and testbench

Parametrised AHB slave memory responder for the verification environment: the next generation of the bench-side AHB interface, generalised in data width, memory depth and wait-state count. Accepts SINGLE, INCR and fixed-length INCR/WRAP bursts and stores data in an internal byte-lane memory. Checks every SEQ beat against the expected burst address and returns two-cycle ERROR responses for illegal transfers. Sits behind the AHB interface as the default slave that the wrap/burst tests drive against.

---
 rtl/ahb_burst_slave.sv | 127 ++++++++++++
 tb/tb_ahb_burst_slave.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_slave.sv
// ahb_burst_slave: AHB slave memory responder with burst-address checking and ERROR responses
// Ports: HCLK/HRESET (async active-low) clock and reset; HSEL, HADDR, HWRITE, HSIZE, HBURST,
// HTRANS, HWDATA bus inputs; HRDATA, HREADY, HRESP bus outputs; seq_err sticky burst-violation
// flag; burst_done pulse on the final OKAY beat of a fixed-length burst.
module ahb_burst_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic [1:0]            HRESP,
  output logic                  seq_err,
  output logic                  burst_done
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEM_DEPTH * NB);
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic acc, sq, bad, sq_bad, last, we, rd_en, wlast;
  logic b_open, b_wrap, cur_wrap, d_valid, d_write, d_last;
  logic [4:0] b_cnt, b_len, cur_cnt, cur_len;
  logic [2:0] b_size, cur_size, d_size, wcnt;
  logic [ADDR_WIDTH-1:0] exp_nx, d_addr, off;
  logic [IW-1:0] raddr, d_idx;
  logic [NB-1:0] lanes;
  logic [DATA_WIDTH-1:0] rword;
  function automatic logic [IW-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    return IW'((a - BASE_ADDR) >> LB);
  endfunction
  // next beat address; a wrap keeps the bits above the len*size boundary
  function automatic logic [ADDR_WIDTH-1:0] nxt(input logic [ADDR_WIDTH-1:0] a,
      input logic [2:0] sz, input logic wrap, input logic [4:0] len);
    logic [ADDR_WIDTH-1:0] inc, m;
    inc = a + (ADDR_WIDTH'(1) << sz);
    m = (ADDR_WIDTH'(len) << sz) - ADDR_WIDTH'(1);
    return wrap ? (a & ~m) | (inc & m) : inc;
  endfunction
  assign acc = HSEL & HREADY & HTRANS[1];
  assign sq = HTRANS == 2'b11;
  assign off = HADDR - BASE_ADDR;
  assign sq_bad = sq && (!b_open || HADDR != exp_nx);
  assign bad = HADDR < BASE_ADDR || off >= SPAN || HSIZE > 3'(LB) || sq_bad ||
               |(HADDR & ADDR_WIDTH'((32'd1 << HSIZE) - 32'd1));
  assign cur_len = sq ? b_len : HBURST[2:1] == 2'd0 ? 5'd0 : 5'd2 << HBURST[2:1];
  assign cur_cnt = sq ? b_cnt + 5'd1 : 5'd1;
  assign cur_wrap = sq ? b_wrap : HBURST[2:1] != 2'd0 && !HBURST[0];
  assign cur_size = sq ? b_size : HSIZE;
  assign last = cur_len != 5'd0 && cur_cnt == cur_len;
  assign wlast = state == WAIT && int'(wcnt) == WAIT_STATES - 1;
  assign we = state == IDLE && d_valid && d_write;
  assign rd_en = (acc && !bad && !HWRITE && WAIT_STATES == 0) || (wlast && !d_write);
  assign d_idx = idx(d_addr);
  assign raddr = state == WAIT ? d_idx : idx(HADDR);
  assign lanes = NB'(~({NB{1'b1}} << (1 << d_size)) << d_addr[LB-1:0]);
  always_comb begin
    HREADY = state != WAIT && state != ERR1;
    HRESP = {1'b0, state == ERR1 || state == ERR2};
    burst_done = state == IDLE && d_valid && d_last;
    state_nx = state == ERR1 ? ERR2 : state == WAIT ? (wlast ? IDLE : WAIT) :
               !acc ? IDLE : bad ? ERR1 : WAIT_STATES > 0 ? WAIT : IDLE;
  end
  // a write committing this cycle is forwarded to a read of the same word
  always_comb begin
    rword = mem[raddr];
    for (int i = 0; i < NB; i++)
      if (we && lanes[i] && d_idx == raddr) rword[8*i +: 8] = HWDATA[8*i +: 8];
  end
  always_ff @(posedge HCLK or negedge HRESET)
    if (!HRESET) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge HCLK)
    if (we)
      for (int i = 0; i < NB; i++)
        if (lanes[i]) mem[d_idx][8*i +: 8] <= HWDATA[8*i +: 8];
  always_ff @(posedge HCLK or negedge HRESET)
    if (!HRESET) begin
      HRDATA <= '0;
      seq_err <= 1'b0;
      wcnt <= 3'd0;
      d_valid <= 1'b0;
      d_write <= 1'b0;
      d_last <= 1'b0;
      d_addr <= '0;
      d_size <= 3'd0;
      b_open <= 1'b0;
      b_cnt <= 5'd0;
      b_len <= 5'd0;
      b_wrap <= 1'b0;
      b_size <= 3'd0;
      exp_nx <= '0;
    end else begin
      if (rd_en) HRDATA <= rword;
      wcnt <= state == WAIT ? wcnt + 3'd1 : 3'd0;
      if (HREADY) d_valid <= acc && !bad;
      if (acc) begin
        d_write <= HWRITE;
        d_addr <= HADDR;
        d_size <= HSIZE;
        d_last <= last;
        if (sq_bad) seq_err <= 1'b1;
        if (bad) b_open <= 1'b0;
        else begin
          b_open <= (sq || HBURST != 3'd0) && !last;
          b_cnt <= cur_cnt;
          b_len <= cur_len;
          b_wrap <= cur_wrap;
          b_size <= cur_size;
          exp_nx <= nxt(HADDR, cur_size, cur_wrap, cur_len);
        end
      end
    end
endmodule

// File: tb/tb_ahb_burst_slave.sv
// tb_ahb_burst_slave: directed bench for ahb_burst_slave with zero-wait and two-wait instances
module tb_ahb_burst_slave;
  localparam logic [1:0] IDL = 2'b00, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SGL = 3'b000, WR4 = 3'b010, INC4 = 3'b011, INC8 = 3'b101;
  localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;
  logic HCLK = 1'b0, HRESET, HSEL0, HSEL2, HWRITE, use2;
  logic [31:0] HADDR, HWDATA;
  logic [2:0] HSIZE, HBURST;
  logic [1:0] HTRANS;
  logic [31:0] HRDATA0, HRDATA2;
  logic HREADY0, HREADY2, seq_err0, seq_err2, burst_done0, burst_done2;
  logic [1:0] HRESP0, HRESP2;
  int n_cmp = 0, n_bad = 0, lw;
  logic [1:0] lr1, lresp;
  logic [31:0] lrd;
  logic ldone;
  logic [31:0] av [4];
  always #5 HCLK = ~HCLK;
  ahb_burst_slave #(.WAIT_STATES(0)) u0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HRDATA(HRDATA0), .HREADY(HREADY0), .HRESP(HRESP0), .seq_err(seq_err0),
    .burst_done(burst_done0));
  ahb_burst_slave #(.WAIT_STATES(2)) u2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL2), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HRDATA(HRDATA2), .HREADY(HREADY2), .HRESP(HRESP2), .seq_err(seq_err2),
    .burst_done(burst_done2));
  wire hrdy = use2 ? HREADY2 : HREADY0;
  wire [1:0] hresp = use2 ? HRESP2 : HRESP0;
  wire [31:0] hrd = use2 ? HRDATA2 : HRDATA0;
  wire hdone = use2 ? burst_done2 : burst_done0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // presents one address phase (wd is data for the previous transfer) and records
  // how the previous data phase completed: wait cycles, first-wait HRESP, final outputs
  task automatic cyc(input logic [1:0] t, input logic [31:0] a, input logic w,
                     input logic [2:0] s, input logic [2:0] b, input logic [31:0] wd);
    HTRANS = t; HADDR = a; HWRITE = w; HSIZE = s; HBURST = b; HWDATA = wd;
    HSEL0 = !use2; HSEL2 = use2;
    lw = 0;
    @(negedge HCLK);
    while (!hrdy && lw < 16) begin
      if (lw == 0) lr1 = hresp;
      lw++;
      @(negedge HCLK);
    end
    if (!hrdy) check("hready_timeout", 32'(hrdy), 32'd1);
    lresp = hresp; lrd = hrd; ldone = hdone;
    @(posedge HCLK); #1;
  endtask
  task automatic err_obs(input string tag);
    check({tag, "_waits"}, lw, 1);
    check({tag, "_resp1"}, 32'(lr1), 32'd1);
    check({tag, "_resp2"}, 32'(lresp), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    HRESET = 1'b0; HSEL0 = 0; HSEL2 = 0; HTRANS = IDL; HADDR = 0; HWRITE = 0;
    HSIZE = SW; HBURST = SGL; HWDATA = 0; use2 = 0;
    av = '{32'hA0A0_0001, 32'hA1A1_0002, 32'hA2A2_0003, 32'hA3A3_0004};
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_hready", 32'(HREADY0), 32'd1);
    check("rst_hresp", 32'(HRESP0), 32'd0);
    check("rst_hrdata", HRDATA0, 32'd0);
    check("rst_seq_err", 32'(seq_err0), 32'd0);
    check("rst_done", 32'(burst_done0), 32'd0);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    cyc(NS, 32'h10, 1, SW, SGL, 0);
    cyc(IDL, 0, 0, SW, SGL, 32'hDEADBEEF);
    check("t1_wr_waits", lw, 0);
    check("t1_wr_resp", 32'(lresp), 32'd0);
    cyc(NS, 32'h10, 0, SW, SGL, 0);
    cyc(IDL, 0, 0, SW, SGL, 0);
    check("t1_rd_data", lrd, 32'hDEADBEEF);
    check("t1_rd_waits", lw, 0);
    cyc(NS, 32'h20, 1, SW, SGL, 0);
    cyc(NS, 32'h20, 0, SW, SGL, 32'h1234_5678);
    cyc(IDL, 0, 0, SW, SGL, 0);
    check("raw_data", lrd, 32'h1234_5678);
    cyc(NS, 32'h38, 1, SW, WR4, 0);
    cyc(SQ, 32'h3C, 1, SW, WR4, 32'hD0);
    cyc(SQ, 32'h30, 1, SW, WR4, 32'hD1);
    cyc(SQ, 32'h34, 1, SW, WR4, 32'hD2);
    check("t2_beat3_done", 32'(ldone), 32'd0);
    check("t2_beat3_resp", 32'(lresp), 32'd0);
    cyc(IDL, 0, 0, SW, SGL, 32'hD3);
    check("t2_beat4_done", 32'(ldone), 32'd1);
    check("t2_beat4_waits", lw, 0);
    check("t2_seq_err_clear", 32'(seq_err0), 32'd0);
    cyc(NS, 32'h30, 0, SW, SGL, 0);
    cyc(NS, 32'h3C, 0, SW, SGL, 0);
    check("t2_rd_30", lrd, 32'hD2);
    cyc(IDL, 0, 0, SW, SGL, 0);
    check("t2_rd_3c", lrd, 32'hD1);
    cyc(NS, 32'h38, 1, SW, WR4, 0);
    cyc(SQ, 32'h3C, 1, SW, WR4, 32'hE0);
    cyc(SQ, 32'h40, 1, SW, WR4, 32'hE1);
    cyc(IDL, 0, 0, SW, SGL, 32'hE2);
    err_obs("t2_bad_seq");
    check("t2_seq_err_set", 32'(seq_err0), 32'd1);
    cyc(NS, 32'h0, 1, SW, SGL, 0);
    cyc(NS, 32'hFFC, 1, SW, SGL, 32'h0BADF00D);
    cyc(NS, 32'h1000, 1, SW, SGL, 32'h5A5A0FFC);
    cyc(IDL, 0, 0, SW, SGL, 32'hFFFF_FFFF);
    err_obs("t4_oor");
    cyc(NS, 32'hFFC, 0, SW, SGL, 0);
    cyc(NS, 32'h0, 0, SW, SGL, 0);
    check("t4_rd_last", lrd, 32'h5A5A0FFC);
    cyc(IDL, 0, 0, SW, SGL, 0);
    check("t4_rd_word0", lrd, 32'h0BADF00D);
    cyc(NS, 32'h10, 1, SW, SGL, 0);
    cyc(NS, 32'h13, 1, SB, SGL, 32'h1122_3344);
    cyc(NS, 32'h11, 1, SH, SGL, 32'hAB00_0000);
    check("t5_byte_resp", 32'(lresp), 32'd0);
    cyc(IDL, 0, 0, SW, SGL, 32'hFFFF_FFFF);
    err_obs("t5_misaligned");
    cyc(NS, 32'h10, 0, SW, SGL, 0);
    cyc(IDL, 0, 0, SW, SGL, 0);
    check("t5_rd_merge", lrd, 32'hAB22_3344);
    use2 = 1;
    cyc(NS, 32'h0, 1, SW, INC4, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(i < 3 ? SQ : IDL, 32'(4 * (i + 1)), 1, SW, INC4, av[i]);
      check($sformatf("t3_wr%0d_waits", i), lw, 2);
    end
    check("t3_wr_done", 32'(ldone), 32'd1);
    cyc(NS, 32'h0, 0, SW, INC4, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(i < 3 ? SQ : IDL, 32'(4 * (i + 1)), 0, SW, INC4, 0);
      check($sformatf("t3_rd%0d_waits", i), lw, 2);
      check($sformatf("t3_rd%0d_data", i), lrd, av[i]);
      check($sformatf("t3_rd%0d_done", i), 32'(ldone), 32'(i == 3));
    end
    cyc(NS, 32'h88, 1, SW, SGL, 0);
    cyc(IDL, 0, 0, SW, SGL, 32'h8888_8888);
    cyc(NS, 32'h80, 1, SW, INC8, 0);
    cyc(SQ, 32'h84, 1, SW, INC8, 32'hB0);
    cyc(SQ, 32'h88, 1, SW, INC8, 32'hB1);
    HTRANS = IDL; HWDATA = 32'hB2;
    check("t6_pre_hready", 32'(HREADY2), 32'd0);
    HRESET = 1'b0;
    #1;
    check("t6_rst_hready", 32'(HREADY2), 32'd1);
    check("t6_rst_hresp", 32'(HRESP2), 32'd0);
    check("t6_rst_hrdata", HRDATA2, 32'd0);
    check("t6_rst_done", 32'(burst_done2), 32'd0);
    check("t6_rst_seq_err0", 32'(seq_err0), 32'd0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    cyc(SQ, 32'h8C, 1, SW, INC8, 0);
    cyc(IDL, 0, 0, SW, SGL, 32'hFFFF_FFFF);
    err_obs("t6_seq_after_rst");
    check("t6_seq_err", 32'(seq_err2), 32'd1);
    cyc(NS, 32'h8C, 1, SW, SGL, 0);
    cyc(IDL, 0, 0, SW, SGL, 32'h8C8C_8C8C);
    check("t6_fresh_waits", lw, 2);
    check("t6_fresh_resp", 32'(lresp), 32'd0);
    cyc(NS, 32'h88, 0, SW, SGL, 0);
    cyc(IDL, 0, 0, SW, SGL, 0);
    check("t6_no_write", lrd, 32'h8888_8888);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
